// File: rtl/wb_stage_pipelined_pkg.sv
// Shared types and constants for the write-back stage: result-source select,
// load funct3 encodings and FSM state.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_IMM  = 2'b11
    } wb_sel_e;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_LOAD
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/wb_stage_pipelined_load_align.sv
// Combinational load aligner: picks the addressed byte/half/word out of the
// raw memory word and sign- or zero-extends it to XLEN.
module load_align
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      funct3,
    input  logic [2:0]      off,
    output logic [XLEN-1:0] result
);

    logic [2:0]      eff_off;
    logic [5:0]      shamt;
    logic [XLEN-1:0] sh;

    // On a 32-bit datapath only two offset bits address within the word
    assign eff_off = (XLEN == 64) ? off : {1'b0, off[1:0]};

    // Offset bits below the access size are dropped, so misaligned bits are ignored
    always_comb begin
        shamt = '0;
        case (funct3)
            F3_LB, F3_LBU: shamt = {eff_off, 3'b000};
            F3_LH, F3_LHU: shamt = {eff_off[2:1], 4'b0000};
            F3_LW, F3_LWU: shamt = {eff_off[2], 5'b00000};
            default:       shamt = '0;
        endcase
    end

    assign sh = rdata >> shamt;

    always_comb begin
        result = '0;
        case (funct3)
            F3_LB:   result = XLEN'($signed(sh[7:0]));
            F3_LH:   result = XLEN'($signed(sh[15:0]));
            F3_LW:   result = XLEN'($signed(sh[31:0]));
            F3_LBU:  result = XLEN'(sh[7:0]);
            F3_LHU:  result = XLEN'(sh[15:0]);
            F3_LD:   result = (XLEN == 64) ? sh : '0;
            F3_LWU:  result = (XLEN == 64) ? XLEN'(sh[31:0]) : '0;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/wb_stage_pipelined.sv
// Registered write-back stage: selects the retiring result, waits for load
// responses, drives the register-file/forwarding ports and counts retirements.
module wb_stage_pipelined
    import wb_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned REG_AW    = 5,
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_ma_valid,
    output logic                 o_wb_ready,
    input  logic [1:0]           i_ma_wb_sel,
    input  logic                 i_ma_reg_we,
    input  logic [REG_AW-1:0]    i_ma_rd,
    input  logic [2:0]           i_ma_funct3,
    input  logic [2:0]           i_ma_addr_lo,
    input  logic [XLEN-1:0]      i_ma_result,
    input  logic [XLEN-1:0]      i_ma_pc_plus4,
    input  logic [XLEN-1:0]      i_ma_imm,
    input  logic                 i_dm_rvalid,
    input  logic [XLEN-1:0]      i_dm_rdata,
    output logic                 o_rf_we,
    output logic [REG_AW-1:0]    o_rf_waddr,
    output logic [XLEN-1:0]      o_rf_wdata,
    output logic                 o_fwd_valid,
    output logic [REG_AW-1:0]    o_fwd_rd,
    output logic [XLEN-1:0]      o_fwd_data,
    output logic                 o_retire,
    output logic [INSTRET_W-1:0] o_instret
);

    wb_state_e         state, state_nxt;
    wb_sel_e           sel;
    logic              accept;
    logic              commit_now;
    logic              commit_load;
    logic [XLEN-1:0]   sel_value;
    logic [XLEN-1:0]   load_value;

    logic [REG_AW-1:0] cap_rd;
    logic              cap_we;
    logic [2:0]        cap_funct3;
    logic [2:0]        cap_addr_lo;

    assign sel         = wb_sel_e'(i_ma_wb_sel);
    assign accept      = i_ma_valid && o_wb_ready;
    assign commit_now  = accept && (sel != WB_SEL_LOAD);
    assign commit_load = (state == ST_WAIT_LOAD) && i_dm_rvalid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (accept && sel == WB_SEL_LOAD) state_nxt = ST_WAIT_LOAD;
            ST_WAIT_LOAD: if (i_dm_rvalid) state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_wb_ready = (state == ST_IDLE) && !i_rst;
    end

    always_comb begin
        sel_value = i_ma_result;
        case (sel)
            WB_SEL_PC4: sel_value = i_ma_pc_plus4;
            WB_SEL_IMM: sel_value = i_ma_imm;
            default:    sel_value = i_ma_result;
        endcase
    end

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .rdata  (i_dm_rdata),
        .funct3 (cap_funct3),
        .off    (cap_addr_lo),
        .result (load_value)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cap_rd      <= '0;
            cap_we      <= 1'b0;
            cap_funct3  <= '0;
            cap_addr_lo <= '0;
        end else if (accept && sel == WB_SEL_LOAD) begin
            cap_rd      <= i_ma_rd;
            cap_we      <= i_ma_reg_we;
            cap_funct3  <= i_ma_funct3;
            cap_addr_lo <= i_ma_addr_lo;
        end
    end

    // Strobes default low each edge; address/data hold until the next commit
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rf_we    <= 1'b0;
            o_rf_waddr <= '0;
            o_rf_wdata <= '0;
            o_retire   <= 1'b0;
            o_instret  <= '0;
        end else begin
            o_rf_we  <= 1'b0;
            o_retire <= 1'b0;
            if (commit_now) begin
                o_rf_we    <= i_ma_reg_we && (i_ma_rd != '0);
                o_rf_waddr <= i_ma_rd;
                o_rf_wdata <= sel_value;
                o_retire   <= 1'b1;
                o_instret  <= o_instret + INSTRET_W'(1);
            end else if (commit_load) begin
                o_rf_we    <= cap_we && (cap_rd != '0);
                o_rf_waddr <= cap_rd;
                o_rf_wdata <= load_value;
                o_retire   <= 1'b1;
                o_instret  <= o_instret + INSTRET_W'(1);
            end
        end
    end

    assign o_fwd_valid = o_rf_we;
    assign o_fwd_rd    = o_rf_waddr;
    assign o_fwd_data  = o_rf_wdata;

endmodule
